// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: operand forwarding, imm select, 2-entry skid buffer
// Optional stall counter enabled by defining ALU_ISSUE_STALL_COUNT_EN.
module alu_issue_stage #(
   parameter int XLEN  = 32,
   parameter int CTL_W = 7,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CTL_W-1:0] in_aluctl,
   input  logic [REG_W-1:0] in_rs1_idx,
   input  logic [REG_W-1:0] in_rs2_idx,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_use_imm,
   input  logic [REG_W-1:0] in_rd_idx,
   input  logic             fwd_ex_valid,
   input  logic [REG_W-1:0] fwd_ex_rd,
   input  logic [XLEN-1:0]  fwd_ex_data,
   input  logic             fwd_wb_valid,
   input  logic [REG_W-1:0] fwd_wb_rd,
   input  logic [XLEN-1:0]  fwd_wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CTL_W-1:0] out_aluctl,
   output logic [XLEN-1:0]  out_a,
   output logic [XLEN-1:0]  out_b,
   output logic [REG_W-1:0] out_rd_idx,
   output logic             out_alu_enable
`ifdef ALU_ISSUE_STALL_COUNT_EN
   ,
   output logic [31:0]      stall_count
`endif
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t state_q, state_d;
   logic   in_ready_q;
   logic   head_valid, accept, consume;
   logic   ld_head_new, ld_head_skid, ld_skid;

   logic [CTL_W-1:0] head_ctl_q, skid_ctl_q;
   logic [XLEN-1:0]  head_a_q, head_b_q, skid_a_q, skid_b_q;
   logic [REG_W-1:0] head_rd_q, skid_rd_q;
   logic [XLEN-1:0]  res_a, res_b;

   assign head_valid = (state_q != S_EMPTY);
   assign accept     = in_valid && in_ready_q && !flush;
   assign consume    = head_valid && out_ready;
   assign in_ready   = in_ready_q;

   // EX result is younger than WB, so it wins; x0 is hardwired and never forwards.
   always_comb begin
      res_a = in_rs1_data;
      if (in_rs1_idx != '0 && fwd_ex_valid && fwd_ex_rd == in_rs1_idx)
         res_a = fwd_ex_data;
      else if (in_rs1_idx != '0 && fwd_wb_valid && fwd_wb_rd == in_rs1_idx)
         res_a = fwd_wb_data;

      res_b = in_rs2_data;
      if (in_use_imm)
         res_b = in_imm;
      else if (in_rs2_idx != '0 && fwd_ex_valid && fwd_ex_rd == in_rs2_idx)
         res_b = fwd_ex_data;
      else if (in_rs2_idx != '0 && fwd_wb_valid && fwd_wb_rd == in_rs2_idx)
         res_b = fwd_wb_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != S_TWO);
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: if (accept) state_d = S_ONE;
            S_ONE: begin
               if (accept && !consume)
                  state_d = S_TWO;
               else if (!accept && consume)
                  state_d = S_EMPTY;
            end
            S_TWO:   if (consume) state_d = S_ONE;
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid      = head_valid;
      out_alu_enable = head_valid;
      ld_head_new    = 1'b0;
      ld_head_skid   = 1'b0;
      ld_skid        = 1'b0;
      if (!flush) begin
         case (state_q)
            S_EMPTY: ld_head_new = accept;
            S_ONE: begin
               ld_head_new = accept && consume;
               ld_skid     = accept && !consume;
            end
            S_TWO:   ld_head_skid = consume;
            default: ;
         endcase
      end
   end

   // Head registers drive the ALU directly; they only change on a load, so
   // stalled or drained outputs keep their last value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_ctl_q <= '0;
         head_a_q   <= '0;
         head_b_q   <= '0;
         head_rd_q  <= '0;
         skid_ctl_q <= '0;
         skid_a_q   <= '0;
         skid_b_q   <= '0;
         skid_rd_q  <= '0;
      end else begin
         if (ld_head_new) begin
            head_ctl_q <= in_aluctl;
            head_a_q   <= res_a;
            head_b_q   <= res_b;
            head_rd_q  <= in_rd_idx;
         end else if (ld_head_skid) begin
            head_ctl_q <= skid_ctl_q;
            head_a_q   <= skid_a_q;
            head_b_q   <= skid_b_q;
            head_rd_q  <= skid_rd_q;
         end
         if (ld_skid) begin
            skid_ctl_q <= in_aluctl;
            skid_a_q   <= res_a;
            skid_b_q   <= res_b;
            skid_rd_q  <= in_rd_idx;
         end
      end
   end

   assign out_aluctl = head_ctl_q;
   assign out_a      = head_a_q;
   assign out_b      = head_b_q;
   assign out_rd_idx = head_rd_q;

`ifdef ALU_ISSUE_STALL_COUNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (head_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [6:0]  in_aluctl;
   logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic        in_use_imm;
   logic        fwd_ex_valid, fwd_wb_valid;
   logic [4:0]  fwd_ex_rd, fwd_wb_rd;
   logic [31:0] fwd_ex_data, fwd_wb_data;
   logic        out_valid, out_ready, out_alu_enable;
   logic [6:0]  out_aluctl;
   logic [31:0] out_a, out_b;
   logic [4:0]  out_rd_idx;
`ifdef ALU_ISSUE_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_aluctl(in_aluctl),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_idx(in_rd_idx),
      .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_aluctl(out_aluctl),
      .out_a(out_a), .out_b(out_b), .out_rd_idx(out_rd_idx),
      .out_alu_enable(out_alu_enable)
`ifdef ALU_ISSUE_STALL_COUNT_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  ctl;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic        use_imm;
      logic        exv, wbv;
      logic [4:0]  exrd, wbrd;
      logic [31:0] exd, wbd;
      logic [31:0] exp_a, exp_b;
   } vec_t;

   typedef struct {
      logic [6:0]  ctl;
      logic [31:0] a, b;
      logic [4:0]  rd;
   } op_t;

   int   n_cmp = 0;
   int   n_fail = 0;
   op_t  mq[$];
   op_t  last_head;
   logic m_ready;
   logic [31:0] m_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 5'd0) return rf;
      if (fwd_ex_valid && fwd_ex_rd == idx) return fwd_ex_data;
      if (fwd_wb_valid && fwd_wb_rd == idx) return fwd_wb_data;
      return rf;
   endfunction

   // One clock: update the reference queue at the edge, compare at the falling edge.
   task automatic tick();
      op_t nop;
      logic acc;
      @(posedge clk);
      acc = in_valid && m_ready && !flush;
      nop.ctl = in_aluctl;
      nop.a   = pick(in_rs1_idx, in_rs1_data);
      nop.b   = in_use_imm ? in_imm : pick(in_rs2_idx, in_rs2_data);
      nop.rd  = in_rd_idx;
      if (!rst_n) begin
         mq.delete();
         last_head = '{ctl: 7'd0, a: 32'd0, b: 32'd0, rd: 5'd0};
         m_ready   = 1'b0;
         m_stall   = 32'd0;
      end else begin
         if (mq.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (flush) mq.delete();
         else begin
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back(nop);
         end
         m_ready = (mq.size() < 2);
      end
      if (mq.size() > 0) last_head = mq[0];
      @(negedge clk);
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      check("alu_enable", {31'd0, out_alu_enable}, {31'd0, mq.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      check("out_aluctl", {25'd0, out_aluctl}, {25'd0, last_head.ctl});
      check("out_a", out_a, last_head.a);
      check("out_b", out_b, last_head.b);
      check("out_rd_idx", {27'd0, out_rd_idx}, {27'd0, last_head.rd});
`ifdef ALU_ISSUE_STALL_COUNT_EN
      check("stall_count", stall_count, m_stall);
`endif
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; fwd_ex_valid = 0; fwd_wb_valid = 0; in_use_imm = 0;
   endtask

   task automatic drive_vec(input vec_t v);
      in_aluctl = v.ctl; in_rs1_idx = v.rs1; in_rs2_idx = v.rs2; in_rd_idx = v.rd;
      in_rs1_data = v.d1; in_rs2_data = v.d2; in_imm = v.imm; in_use_imm = v.use_imm;
      fwd_ex_valid = v.exv; fwd_ex_rd = v.exrd; fwd_ex_data = v.exd;
      fwd_wb_valid = v.wbv; fwd_wb_rd = v.wbrd; fwd_wb_data = v.wbd;
      in_valid = 1'b1;
   endtask

   task automatic drive_simple(input logic [31:0] a);
      vec_t v;
      v = '{ctl: 7'h01, rs1: 5'd10, rs2: 5'd11, rd: 5'd12, d1: a, d2: ~a, imm: 32'd0,
            use_imm: 1'b0, exv: 1'b0, wbv: 1'b0, exrd: 5'd0, wbrd: 5'd0, exd: 32'd0,
            wbd: 32'd0, exp_a: a, exp_b: ~a};
      drive_vec(v);
   endtask

   task automatic do_reset();
      idle_inputs();
      out_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic vec_t mk(input logic [4:0] rs1, input logic [31:0] d1,
                               input logic [4:0] rs2, input logic [31:0] d2,
                               input logic ui, input logic [31:0] imm,
                               input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                               input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                               input logic [31:0] ea, input logic [31:0] eb);
      vec_t v;
      v = '{ctl: 7'h00, rs1: rs1, rs2: rs2, rd: 5'd31, d1: d1, d2: d2, imm: imm,
            use_imm: ui, exv: exv, wbv: wbv, exrd: exrd, wbrd: wbrd, exd: exd,
            wbd: wbd, exp_a: ea, exp_b: eb};
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      logic [31:0] got[$];
      logic [31:0] want[3];
      logic pre_ready;

      in_aluctl = '0; in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0;
      in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
      fwd_ex_rd = '0; fwd_wb_rd = '0; fwd_ex_data = '0; fwd_wb_data = '0;
      m_ready = 1'b0; m_stall = '0;
      last_head = '{ctl: 7'd0, a: 32'd0, b: 32'd0, rd: 5'd0};

      vecs[0] = mk(5'd1, 32'd5,    5'd2, 32'd7,    0, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'd7);
      vecs[1] = mk(5'd3, 32'h10,   5'd4, 32'h20,   0, 0, 1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 32'hAA, 32'h20);
      vecs[2] = mk(5'd3, 32'h10,   5'd4, 32'h20,   0, 0, 0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 32'hBB, 32'h20);
      vecs[3] = mk(5'd0, 32'h1234, 5'd5, 32'h55,   0, 0, 1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, 32'h1234, 32'h55);
      vecs[4] = mk(5'd7, 32'h70,   5'd6, 32'h66,   1, 32'hFFFF_FFF0, 1, 5'd6, 32'hCC, 0, 0, 0, 32'h70, 32'hFFFF_FFF0);
      vecs[5] = mk(5'd8, 32'h80,   5'd9, 32'h90,   0, 0, 1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 32'h88, 32'h99);

      do_reset();
      check("rst_out_a", out_a, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single ops from EMPTY: one-cycle latency, then EMPTY again after consume.
      for (int i = 0; i < 6; i++) begin
         out_ready = 1'b1;
         drive_vec(vecs[i]);
         tick();
         idle_inputs();
         check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d_a", i), out_a, vecs[i].exp_a);
         check($sformatf("vec%0d_b", i), out_b, vecs[i].exp_b);
         tick();
         check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
      end

      // Backpressure: X, Y accepted, Z held, then all three drain in order.
      want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
      out_ready = 1'b0;
      drive_simple(want[0]); tick();
      drive_simple(want[1]); tick();
      drive_simple(want[2]);
      check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
      tick(); tick();
      check("bp_stall_a", out_a, want[0]);
      out_ready = 1'b1;
      for (int c = 0; c < 10 && got.size() < 3; c++) begin
         pre_ready = in_ready;
         if (out_valid) got.push_back(out_a);
         tick();
         if (in_valid && pre_ready) in_valid = 1'b0;
      end
      if (got.size() < 3) begin
         n_cmp++; n_fail++;
         $display("FAIL bp_drain: got %0d ops expected 3", got.size());
      end else
         for (int k = 0; k < 3; k++) check($sformatf("bp_order%0d", k), got[k], want[k]);
      idle_inputs();

      // Flush with two entries held, then with one entry and in_ready high.
      for (int pass = 0; pass < 2; pass++) begin
         out_ready = 1'b0;
         drive_simple(32'h5A5A_0001); tick();
         if (pass == 0) begin drive_simple(32'h5A5A_0002); tick(); end
         if (pass == 1) check("fl_ready_before", {31'd0, in_ready}, 32'd1);
         drive_simple(32'h77);
         flush = 1'b1;
         tick();
         idle_inputs();
         check("fl_valid", {31'd0, out_valid}, 32'd0);
         check("fl_ready", {31'd0, in_ready}, 32'd1);
         out_ready = 1'b1;
         for (int c = 0; c < 3; c++) begin
            tick();
            check("fl_never_appears", {31'd0, out_valid}, 32'd0);
         end
      end

`ifdef ALU_ISSUE_STALL_COUNT_EN
      do_reset();
      drive_simple(32'h1);
      tick();
      idle_inputs();
      for (int c = 0; c < 10; c++) tick();
      check("sc_ten", stall_count, 32'd10);
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("sc_after_flush", stall_count, 32'd10);
      do_reset();
      check("sc_after_reset", stall_count, 32'd0);
`endif

      // Randomized traffic against the queue model.
      for (int c = 0; c < 2000; c++) begin
         rst_n        = ($urandom_range(0, 199) != 0);
         flush        = ($urandom_range(0, 24) == 0);
         in_valid     = ($urandom_range(0, 3) != 0);
         out_ready    = ($urandom_range(0, 9) < 6);
         in_aluctl    = 7'($urandom);
         in_rs1_idx   = 5'($urandom_range(0, 3));
         in_rs2_idx   = 5'($urandom_range(0, 3));
         in_rd_idx    = 5'($urandom);
         in_rs1_data  = $urandom;
         in_rs2_data  = $urandom;
         in_imm       = $urandom;
         in_use_imm   = ($urandom_range(0, 3) == 0);
         fwd_ex_valid = $urandom_range(0, 1) == 1;
         fwd_ex_rd    = 5'($urandom_range(0, 3));
         fwd_ex_data  = $urandom;
         fwd_wb_valid = $urandom_range(0, 1) == 1;
         fwd_wb_rd    = 5'($urandom_range(0, 3));
         fwd_wb_data  = $urandom;
         tick();
      end
      idle_inputs();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-entry stage directly upstream of the RV32I ALU.
- Accepts decoded ALU operations from decode over a valid/ready handshake and resolves operand forwarding from the EX/MEM and MEM/WB results.
- Selects register or immediate for operand B.
- Presents registered ALUctl/A/B/alu_enable to the ALU through a 2-entry skid buffer, so backpressure never creates a combinational ready path.

Parameters:
- XLEN, 32, datapath width of operands and forwarded results.
- CTL_W, 7, width of the ALU control field, carried unmodified.
- REG_W, 5, register index width.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  kill all held entries (branch mispredict/trap)
- in_valid  input  1  decode presents an op
- in_ready  output  1  stage can accept an op this cycle
- in_aluctl  input  CTL_W  ALU control for the op
- in_rs1_idx, in_rs2_idx  input  REG_W  source register indices
- in_rs1_data, in_rs2_data  input  XLEN  register-file read data
- in_imm  input  XLEN  sign-extended immediate
- in_use_imm  input  1  1: operand B = in_imm
- in_rd_idx  input  REG_W  destination index, carried through
- fwd_ex_valid  input  1  EX/MEM result writes a register
- fwd_ex_rd  input  REG_W  EX/MEM destination
- fwd_ex_data  input  XLEN  EX/MEM result
- fwd_wb_valid  input  1  MEM/WB result writes a register
- fwd_wb_rd  input  REG_W  MEM/WB destination
- fwd_wb_data  input  XLEN  MEM/WB result
- out_valid  output  1  op presented to ALU
- out_ready  input  1  downstream consumes op this cycle
- out_aluctl  output  CTL_W  to ALU ALUctl
- out_a, out_b  output  XLEN  to ALU A, B
- out_rd_idx  output  REG_W  destination index
- out_alu_enable  output  1  equals out_valid

Behaviour:
- Reset (rst_n low at edge): both entries invalid; out_valid=0, out_alu_enable=0, all out_* data=0.
- in_ready is 0 while rst_n is sampled low and 1 on the first cycle after release.
- Operand resolution happens at acceptance (in_valid && in_ready), combinationally from current inputs:
  - A = fwd_ex_data if fwd_ex_valid && fwd_ex_rd==in_rs1_idx && in_rs1_idx!=0; else fwd_wb_data under the same rule with wb; else in_rs1_data.
  - B is the same rule on rs2, unless in_use_imm=1, in which case B = in_imm (no forwarding).
  - EX takes priority over WB. Index 0 never forwards.
- Entries store resolved values; forwarding inputs are not re-sampled after acceptance.
- State machine on occupancy:
  - EMPTY: accept -> ONE.
  - ONE: accept without consume -> TWO; consume without accept -> EMPTY; both -> ONE with the new op at the head next cycle.
  - TWO: in_ready=0; consume -> ONE, skid entry moves to head.
- Latency: accepted op appears on out_* the cycle after acceptance when the stage was EMPTY.
- Order is strictly FIFO. out_* are stable while out_valid && !out_ready.
- in_ready is a registered function of state: 1 in EMPTY/ONE, 0 in TWO. Never combinational from out_ready.
- flush=1: next state EMPTY, out_valid=0. An op offered in the same cycle is dropped, even if in_ready=1.
- Flush overrides consume and accept. rst_n low overrides flush.
- Invalid output data lines hold their last value, except after reset, when they are 0.

Optional Feature:
- ALU_ISSUE_STALL_COUNT_EN defined:
  - Adds output stall_count [31:0]: increments each cycle out_valid && !out_ready, saturates at 0xFFFFFFFF.
  - Cleared only by reset; not by flush.
- Undefined: port and counter absent, behaviour otherwise identical.

Test Plan:
- Reset then single op: aluctl=ADD, rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7; EMPTY again after consume.
- Forward priority: rs1_idx=3, fwd_ex(rd=3, data=0xAA), fwd_wb(rd=3, data=0xBB) -> out_a=0xAA. With fwd_ex_valid=0 -> out_a=0xBB. With rs1_idx=0 -> out_a=in_rs1_data.
- Immediate: in_use_imm=1, imm=0xFFFFFFF0, fwd_ex_rd=rs2_idx -> out_b=0xFFFFFFF0.
- Backpressure: out_ready=0, offer ops X, Y, Z back-to-back -> X, Y accepted, in_ready=0 on cycle 3, Z held; raise out_ready -> X, Y, Z emerge in order, out_* stable while stalled.
- Flush: two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered op never appears.
- With ALU_ISSUE_STALL_COUNT_EN: hold out_ready=0 for 10 cycles with out_valid=1 -> stall_count=10; flush leaves it 10; reset -> 0.
